// File: rtl/booth_prod_accum.sv
// booth_prod_accum
// ----------------
// Multiply-accumulate back end for the 4-bit Booth multiplier. It sums a
// fixed-length batch of N_TERMS signed products into a wider two's-complement
// accumulator. Each batch total is then presented downstream, together with a
// sticky signed-overflow flag.
//
// Ports
//   clk         rising-edge system clock
//   rst_n       asynchronous active-low reset
//   clear       synchronous batch abort; wins over every other event
//   prod        signed product from the multiplier (PROD_W bits)
//   prod_valid  prod is valid this cycle
//   prod_ready  block accepts prod this cycle
//   sum         signed batch total (ACC_W bits)
//   sum_ovf     signed overflow occurred in the batch that produced sum
//   sum_valid   sum / sum_ovf are valid
//   sum_ready   downstream accepts sum
//   term_cnt    products accepted so far in the current batch
//   state_dbg   FSM state for observation (0 = ACCUM, 1 = DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. A producer holds its data and valid stable until that edge.
// prod_ready depends only on the FSM state and clear, never on prod_valid.
// sum/sum_ovf/sum_valid hold until sum_ready is sampled high.

module booth_prod_accum #(
    parameter int PROD_W  = 8,
    parameter int ACC_W   = 12,
    parameter int N_TERMS = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic [PROD_W-1:0] prod,
    input  logic              prod_valid,
    output logic              prod_ready,
    output logic [ACC_W-1:0]  sum,
    output logic              sum_ovf,
    output logic              sum_valid,
    input  logic              sum_ready,
    output logic [7:0]        term_cnt,
    output logic              state_dbg
);

    typedef enum logic {
        ACCUM = 1'b0,
        DONE  = 1'b1
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(N_TERMS - 1);

    state_t                    state_q;
    state_t                    state_d;
    logic signed [ACC_W-1:0]   acc;
    logic signed [ACC_W-1:0]   prod_ext;
    logic signed [ACC_W-1:0]   add_res;
    logic                      add_ovf;
    logic                      ovf_flag;
    logic                      accept;
    logic                      last_term;

    // Products are always two's complement; the size cast sign-extends.
    assign prod_ext = ACC_W'($signed(prod));
    assign add_res  = acc + prod_ext;

    // Overflow: both operands share a sign and the wrapped result does not.
    assign add_ovf = (acc[ACC_W-1] == prod_ext[ACC_W-1]) &&
                     (add_res[ACC_W-1] != acc[ACC_W-1]);

    assign prod_ready = (state_q == ACCUM) && !clear;
    assign accept     = prod_valid && prod_ready;
    assign last_term  = (term_cnt == LAST_CNT);
    assign state_dbg  = (state_q == DONE);

    always_comb begin
        state_d = state_q;
        case (state_q)
            ACCUM: if (accept && last_term) state_d = DONE;
            DONE:  if (sum_ready)           state_d = ACCUM;
            default:                        state_d = ACCUM;
        endcase
        if (clear) state_d = ACCUM;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc       <= '0;
            term_cnt  <= '0;
            ovf_flag  <= 1'b0;
            sum       <= '0;
            sum_ovf   <= 1'b0;
            sum_valid <= 1'b0;
        end else begin
            state_q <= state_d;
            if (clear) begin
                // Abort: drop partial batch and any unconsumed total.
                acc       <= '0;
                term_cnt  <= '0;
                ovf_flag  <= 1'b0;
                sum_valid <= 1'b0;
            end else begin
                if (state_q == DONE && sum_ready) begin
                    sum_valid <= 1'b0;
                end
                if (accept) begin
                    if (last_term) begin
                        // Publish the total and start the next batch clean.
                        sum       <= add_res;
                        sum_ovf   <= ovf_flag | add_ovf;
                        sum_valid <= 1'b1;
                        acc       <= '0;
                        term_cnt  <= '0;
                        ovf_flag  <= 1'b0;
                    end else begin
                        acc      <= add_res;
                        term_cnt <= term_cnt + 8'd1;
                        ovf_flag <= ovf_flag | add_ovf;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_booth_prod_accum.sv
// Bench for booth_prod_accum: two instances (12-bit and 8-bit accumulator),
// a batch-level reference model and directed batches with literal totals.

module tb_booth_prod_accum;

    localparam int N   = 4;
    localparam int AW0 = 12;
    localparam int AW1 = 8;

    logic       clk   = 1'b0;
    logic       rst_n = 1'b0;
    logic [1:0] clear      = 2'b00;
    logic [1:0] prod_valid = 2'b00;
    logic [1:0] sum_ready  = 2'b11;
    logic [7:0] prod [2];
    logic [1:0] prod_ready;
    logic [1:0] sum_ovf;
    logic [1:0] sum_valid;
    logic [1:0] state_dbg;
    logic [11:0] sum0;
    logic [7:0]  sum1;
    logic [7:0]  term_cnt [2];

    int tests = 0;
    int fails = 0;

    // Model: products of the open batch, and the published total {ovf, sum}
    // waiting for the downstream handshake.
    int          bprod [2][N];
    int          bcnt  [2];
    logic [12:0] exp_q0 [$];
    logic [12:0] exp_q1 [$];

    always #5 clk = ~clk;

    booth_prod_accum #(.PROD_W(8), .ACC_W(AW0), .N_TERMS(N)) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear[0]), .prod(prod[0]),
        .prod_valid(prod_valid[0]), .prod_ready(prod_ready[0]), .sum(sum0),
        .sum_ovf(sum_ovf[0]), .sum_valid(sum_valid[0]), .sum_ready(sum_ready[0]),
        .term_cnt(term_cnt[0]), .state_dbg(state_dbg[0])
    );

    booth_prod_accum #(.PROD_W(8), .ACC_W(AW1), .N_TERMS(N)) dut8 (
        .clk(clk), .rst_n(rst_n), .clear(clear[1]), .prod(prod[1]),
        .prod_valid(prod_valid[1]), .prod_ready(prod_ready[1]), .sum(sum1),
        .sum_ovf(sum_ovf[1]), .sum_valid(sum_valid[1]), .sum_ready(sum_ready[1]),
        .term_cnt(term_cnt[1]), .state_dbg(state_dbg[1])
    );

    task automatic check(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t",
                     name, act, act, exp, exp, $time);
        end
    endtask

    function automatic int wrap(input int v, input int w);
        int r;
        r = v & ((1 << w) - 1);
        if (r >= (1 << (w - 1))) r = r - (1 << w);
        return r;
    endfunction

    // Fold the batch with exact integers; overflow whenever a true partial
    // sum leaves the signed range of the accumulator width.
    task automatic close_batch(input int k);
        int run;
        int t;
        int w;
        bit ovf;
        w   = (k == 0) ? AW0 : AW1;
        run = 0;
        ovf = 1'b0;
        for (int i = 0; i < N; i++) begin
            t = run + bprod[k][i];
            if (t > (1 << (w - 1)) - 1 || t < -(1 << (w - 1))) ovf = 1'b1;
            run = wrap(t, w);
        end
        if (k == 0) exp_q0.push_back({ovf, 12'(run)});
        else        exp_q1.push_back({ovf, 12'(run)});
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bcnt[0] = 0;
            bcnt[1] = 0;
            exp_q0.delete();
            exp_q1.delete();
        end else begin
            for (int k = 0; k < 2; k++) begin
                bit pend;
                pend = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
                if (clear[k]) begin
                    bcnt[k] = 0;
                    if (k == 0) exp_q0.delete(); else exp_q1.delete();
                end else if (pend) begin
                    if (sum_ready[k]) begin
                        if (k == 0) void'(exp_q0.pop_front());
                        else        void'(exp_q1.pop_front());
                    end
                end else if (prod_valid[k]) begin
                    bprod[k][bcnt[k]] = int'($signed(prod[k]));
                    bcnt[k] = bcnt[k] + 1;
                    if (bcnt[k] == N) begin
                        close_batch(k);
                        bcnt[k] = 0;
                    end
                end
            end
        end
    end

    // Compare every cycle, on the falling edge.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            bit pend;
            logic [12:0] e;
            pend = (k == 0) ? (exp_q0.size() != 0) : (exp_q1.size() != 0);
            check($sformatf("prod_ready%0d", k), int'(prod_ready[k]), int'(!pend && !clear[k]));
            check($sformatf("sum_valid%0d", k), int'(sum_valid[k]), int'(pend));
            check($sformatf("state_dbg%0d", k), int'(state_dbg[k]), int'(pend));
            check($sformatf("term_cnt%0d", k), int'(term_cnt[k]), bcnt[k]);
            if (pend) begin
                e = (k == 0) ? exp_q0[0] : exp_q1[0];
                if (k == 0) check("sum0", int'(sum0), int'(e[11:0]));
                else        check("sum1", int'(sum1), int'(e[7:0]));
                check($sformatf("sum_ovf%0d", k), int'(sum_ovf[k]), int'(e[12]));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [7:0] p);
        bit done_f;
        done_f = 1'b0;
        prod[k] = p;
        prod_valid[k] = 1'b1;
        for (int i = 0; i < 50 && !done_f; i++) begin
            @(negedge clk);
            done_f = prod_ready[k];
            step();
        end
        prod_valid[k] = 1'b0;
        if (!done_f) begin
            tests++;
            fails++;
            $display("FAIL send%0d: product 0x%0h not accepted within 50 cycles", k, p);
        end
    endtask

    task automatic wait_sum(input int k, input int exp_sum, input int exp_ovf);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            seen = sum_valid[k];
        end
        check($sformatf("batch_valid%0d", k), int'(seen), 1);
        if (k == 0) check("batch_sum0", int'(sum0), exp_sum);
        else        check("batch_sum1", int'(sum1), exp_sum);
        check($sformatf("batch_ovf%0d", k), int'(sum_ovf[k]), exp_ovf);
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        prod[0] = 8'h00;
        prod[1] = 8'h00;

        // Reset values.
        repeat (3) step();
        check("rst_sum0", int'(sum0), 0);
        check("rst_sum_valid", int'(sum_valid[0]), 0);
        check("rst_term_cnt", int'(term_cnt[0]), 0);
        check("rst_prod_ready", int'(prod_ready[0]), 1);
        rst_n = 1'b1;
        step();

        // 15 - 16 + 6 + 1 = 6; one DONE cycle with sum_ready held high.
        send(0, 8'd15); send(0, 8'hF0); send(0, 8'd6); send(0, 8'd1);
        check("t1_valid", int'(sum_valid[0]), 1);
        check("t1_sum", int'(sum0), 'h006);
        check("t1_ovf", int'(sum_ovf[0]), 0);
        check("t1_ready_low", int'(prod_ready[0]), 0);
        step();
        check("t1_ready_back", int'(prod_ready[0]), 1);
        check("t1_valid_drop", int'(sum_valid[0]), 0);

        // Back-pressure: DONE held while an upstream product waits.
        sum_ready[0] = 1'b0;
        send(0, 8'd15); send(0, 8'hF0); send(0, 8'd6); send(0, 8'd1);
        prod[0] = 8'd7;
        prod_valid[0] = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("t2_ready_held", int'(prod_ready[0]), 0);
            check("t2_sum_held", int'(sum0), 6);
        end
        step();
        sum_ready[0] = 1'b1;
        step();
        check("t2_after_hs_valid", int'(sum_valid[0]), 0);
        check("t2_after_hs_cnt", int'(term_cnt[0]), 0);
        step();
        check("t2_first_accept", int'(term_cnt[0]), 1);
        prod_valid[0] = 1'b0;
        send(0, 8'd1); send(0, 8'd1); send(0, 8'd1);
        wait_sum(0, 10, 0);

        // 8-bit accumulator: 64 + 64 wraps to -128 with overflow.
        send(1, 8'd64); send(1, 8'd64); send(1, 8'd0); send(1, 8'd0);
        wait_sum(1, 'h80, 1);
        send(1, 8'd1); send(1, 8'd1); send(1, 8'd1); send(1, 8'd1);
        wait_sum(1, 4, 0);

        // Clear mid-batch drops 10 and 20; offered product is refused.
        send(0, 8'd10); send(0, 8'd20);
        clear[0] = 1'b1;
        prod[0] = 8'd99;
        prod_valid[0] = 1'b1;
        @(negedge clk);
        check("t4_ready_in_clear", int'(prod_ready[0]), 0);
        step();
        clear[0] = 1'b0;
        prod_valid[0] = 1'b0;
        check("t4_cnt_after_clear", int'(term_cnt[0]), 0);
        send(0, 8'd1); send(0, 8'd2); send(0, 8'd3); send(0, 8'd4);
        wait_sum(0, 10, 0);

        // Clear together with sum_ready in DONE: pending total discarded.
        sum_ready[0] = 1'b0;
        send(0, 8'd5); send(0, 8'd5); send(0, 8'd5); send(0, 8'd5);
        check("t5_pending", int'(sum0), 20);
        clear[0] = 1'b1;
        sum_ready[0] = 1'b1;
        step();
        clear[0] = 1'b0;
        check("t5_valid_gone", int'(sum_valid[0]), 0);
        check("t5_state_accum", int'(state_dbg[0]), 0);
        for (int i = 0; i < 3; i++) begin
            step();
            check("t5_no_second_sum", int'(sum_valid[0]), 0);
        end

        // Asynchronous reset between edges after three accepts.
        send(0, 8'd1); send(0, 8'd1); send(0, 8'd1);
        #2;
        rst_n = 1'b0;
        #1;
        check("t6_valid", int'(sum_valid[0]), 0);
        check("t6_cnt", int'(term_cnt[0]), 0);
        check("t6_sum", int'(sum0), 0);
        check("t6_acc", int'(dut.acc), 0);
        step();
        step();
        rst_n = 1'b1;
        step();
        send(0, 8'd1); send(0, 8'd1); send(0, 8'd1); send(0, 8'd1);
        wait_sum(0, 4, 0);

        repeat (3) step();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/booth_prod_accum.md
Name: booth_prod_accum

Overview:
- Consumes the signed 8-bit products produced by the 4-bit Booth multiplier (`ans`).
- Sums a fixed-length batch of N_TERMS products into a wider signed accumulator.
- Presents each batch total to the downstream consumer over a valid/ready handshake.
- This is the multiply-accumulate back end that turns single Booth products into dot-product terms.

Parameters:
- PROD_W, 8, width of the incoming signed product (matches the multiplier `ans` width).
- ACC_W, 12, width of the signed accumulator and the `sum` output; must be ≥ PROD_W.
- N_TERMS, 4, number of products per batch; legal range 1..255.

Ports:
- clk  input  1  single system clock, rising-edge.
- rst_n  input  1  asynchronous active-low reset.
- clear  input  1  synchronous batch abort; wins over every other event in the same cycle.
- prod  input  PROD_W  signed product from the Booth multiplier.
- prod_valid  input  1  `prod` is valid this cycle.
- prod_ready  output  1  block accepts `prod` this cycle.
- sum  output  ACC_W  signed batch total.
- sum_ovf  output  1  signed overflow occurred during the batch that produced `sum`.
- sum_valid  output  1  `sum`/`sum_ovf` are valid.
- sum_ready  input  1  downstream accepts `sum`.
- term_cnt  output  8  number of products accepted in the current batch.

Behaviour:
- Reset (rst_n low, asynchronous): state=ACCUM, acc=0, term_cnt=0, sum=0, sum_ovf=0, sum_valid=0, internal ovf flag=0.
- The state machine has two states: ACCUM and DONE.
- prod_ready is 1 exactly when state=ACCUM and clear=0. It is combinational from state and clear only, never from prod_valid.
- Product acceptance occurs when prod_valid & prod_ready at a clock edge.
  - Update: acc <= acc + sext(prod) to ACC_W. This is two's-complement wrap, not saturation.
  - term_cnt increments by 1.
  - The ovf flag is set if the add overflows: operands share a sign and the result sign differs. The flag is sticky for the batch.
- Last term: the acceptance when term_cnt == N_TERMS-1.
  - sum <= acc + sext(prod).
  - sum_ovf <= ovf flag OR this add's overflow.
  - sum_valid <= 1, state <= DONE.
  - acc, term_cnt and the ovf flag are cleared in the same edge.
  - Latency from last-term acceptance to sum_valid is 1 cycle.
- DONE state:
  - prod_ready=0, so products back-pressure upstream.
  - sum, sum_ovf and sum_valid hold stable until sum_ready is sampled high.
  - On that edge: sum_valid <= 0 and state <= ACCUM, so a new product can be accepted the next cycle.
  - sum retains its last value after the handshake; it is don't-care while sum_valid=0.
- Throughput: one batch per N_TERMS+1 cycles at best. There is no accept in the handshake cycle.
- N_TERMS=1: every accepted product goes straight to DONE, with sum = sext(prod).
- clear=1 (synchronous, any state):
  - acc=0, term_cnt=0, ovf flag=0, sum_valid=0, state=ACCUM.
  - Any product offered that cycle is not accepted (prod_ready=0).
  - A pending unconsumed sum is discarded.
- clear coinciding with sum_ready in DONE: clear wins. The outcome is identical to clear alone.
- prod_valid while in DONE: ignored. Upstream must hold prod and prod_valid until prod_ready.
- Reset mid-batch: all partial state is lost immediately (asynchronous), and outputs return to reset values.
- Sign extension: products are always treated as two's complement, so 8'hF0 = -16.

Test Plan:
- Reset, then feed products 15 (3×5), -16 (8'hF0, i.e. -8×2), 6, 1 with sum_ready=1 → sum_valid rises one cycle after 4th accept; sum=12'h006, sum_ovf=0; prod_ready low for exactly one cycle.
- Same batch but hold sum_ready=0 for 5 cycles while prod_valid=1 with prod=7 → prod_ready stays 0, sum stays 6; after sum_ready pulse, next batch starts with 7 accepted on first ACCUM cycle.
- ACC_W=8, N_TERMS=4, products 64,64,0,0 → second add overflows; sum=8'h80 (-128), sum_ovf=1; next batch of 1,1,1,1 → sum=4, sum_ovf=0 (flag cleared).
- Accept 2 products (10, 20), assert clear for one cycle, then feed 1,2,3,4 → sum=10, term_cnt reads 0 the cycle after clear.
- In DONE with sum_valid=1, drive clear and sum_ready together → sum_valid=0 next cycle, state ACCUM, no second sum emitted.
- Deassert rst_n asynchronously between clock edges after 3 accepted products → sum_valid, term_cnt and acc read 0 immediately; after release, a full batch 1,1,1,1 gives sum=4.
